sm_clk_ctrl: RTL and testbench

Parametrised successor to the fixed power-of-two clock divider. It generates the CPU clock and a matching one-cycle enable pulse from the board clock. The divide ratio is programmable and changes only at period boundaries, so the output never glitches. It adds run, stop and single-step modes, plus a period counter for debug display. It sits between the input debouncers and sr_cpu in the hardware top level.

---
 rtl/sm_clk_ctrl_pkg.sv | 18 +
 rtl/sm_edge_detect.sv | 19 +
 rtl/sm_clk_ctrl.sv | 123 ++++++++++++
 tb/tb_sm_clk_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_clk_ctrl_pkg.sv
// Shared encodings for the programmable CPU clock controller.
// Mode and FSM state enumerations used by the top level and its users.
package sm_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_STOP = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } state_t;

endpackage

// File: rtl/sm_edge_detect.sv
// Registered rising-edge detector for an already debounced level input.
// rise is high in the cycle where din is 1 and its registered copy is still 0.
module sm_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/sm_clk_ctrl.sv
// CPU clock generator: glitch-free programmable divider with run/stop/step modes.
// Divide ratio is latched only on HIGH entry, so every phase is a whole power of two.
import sm_clk_ctrl_pkg::*;

module sm_clk_ctrl #(
  parameter int SHIFT  = 16,
  parameter int DIV_W  = 4,
  parameter int CNT_W  = SHIFT + 2**DIV_W,
  parameter int PCNT_W = 32
) (
  input  logic              clkIn,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  divide,
  input  logic [1:0]        mode,
  input  logic              step,
  output logic              clkOut,
  output logic              tick,
  output logic              busy,
  output logic [PCNT_W-1:0] periods,
  output logic [1:0]        state_dbg
);

  // Handshake-free block: step is a level whose rising edge is a one-shot request;
  // tick is a single-cycle strobe aligned with clkOut rising, no back-pressure.

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_q;
  logic              pending, pending_nxt;
  logic              rise;
  logic              enter_high, enter_low;
  logic              run_mode, step_mode, want_start;
  mode_t             mode_e;

  function automatic logic [CNT_W-1:0] half_load(input logic [DIV_W-1:0] d);
    half_load = (CNT_W'(1) << (SHIFT + int'(d))) - CNT_W'(1);
  endfunction

  sm_edge_detect u_step_edge (
    .clk   (clkIn),
    .rst_n (rst_n),
    .din   (step),
    .rise  (rise)
  );

  assign mode_e     = mode_t'(mode);
  assign run_mode   = (mode_e == MODE_RUN);
  assign step_mode  = (mode_e == MODE_STEP);
  assign want_start = run_mode || (step_mode && (pending || rise));

  always_comb begin
    state_nxt  = state;
    enter_high = 1'b0;
    enter_low  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (want_start) begin
          state_nxt  = ST_HIGH;
          enter_high = 1'b1;
        end
      end
      ST_HIGH: begin
        // High phase always completes, whatever the mode does meanwhile.
        if (cnt == '0) begin
          state_nxt = ST_LOW;
          enter_low = 1'b1;
        end
      end
      ST_LOW: begin
        if (cnt == '0) begin
          if (want_start) begin
            state_nxt  = ST_HIGH;
            enter_high = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Only one step request is ever queued; a rise while one is queued is dropped.
  always_comb begin
    pending_nxt = pending;
    if (!step_mode)      pending_nxt = 1'b0;
    else if (enter_high) pending_nxt = 1'b0;
    else if (rise)       pending_nxt = 1'b1;
  end

  always_ff @(posedge clkIn) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      div_q   <= '0;
      pending <= 1'b0;
      clkOut  <= 1'b0;
      tick    <= 1'b0;
      busy    <= 1'b0;
      periods <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      clkOut  <= (state_nxt == ST_HIGH);
      tick    <= enter_high;
      busy    <= (state_nxt != ST_IDLE);
      if (enter_high) begin
        div_q   <= divide;
        cnt     <= half_load(divide);
        periods <= periods + PCNT_W'(1);
      end else if (enter_low) begin
        cnt <= half_load(div_q);
      end else if (state_nxt == ST_IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Bench for sm_clk_ctrl (SHIFT=1, DIV_W=2): vector table, corner sequences and
// randomized traffic, all checked against a phase-level reference model.
module tb_sm_clk_ctrl;

  localparam int SHIFT  = 1;
  localparam int DIV_W  = 2;
  localparam int PCNT_W = 32;

  logic              clkIn;
  logic              rst_n;
  logic [DIV_W-1:0]  divide;
  logic [1:0]        mode;
  logic              step;
  logic              clkOut;
  logic              tick;
  logic              busy;
  logic [PCNT_W-1:0] periods;
  logic [1:0]        state_dbg;

  int n_checks;
  int n_pass;

  sm_clk_ctrl #(.SHIFT(SHIFT), .DIV_W(DIV_W), .PCNT_W(PCNT_W)) dut (
    .clkIn     (clkIn),
    .rst_n     (rst_n),
    .divide    (divide),
    .mode      (mode),
    .step      (step),
    .clkOut    (clkOut),
    .tick      (tick),
    .busy      (busy),
    .periods   (periods),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  // Reference model: phase name plus remaining cycles in that phase.
  int          m_phase;   // 0 idle, 1 high, 2 low
  int          m_left;
  int          m_div;
  int          m_req;
  logic        m_prev_step;
  logic [31:0] m_periods;
  logic        m_tick;

  task automatic model_edge(input logic r, input logic [1:0] md, input logic [1:0] dv,
                            input logic st);
    logic rise_m;
    logic go;
    logic start;
    if (!r) begin
      m_phase = 0; m_left = 0; m_div = 0; m_req = 0;
      m_prev_step = 1'b0; m_periods = 0; m_tick = 1'b0;
    end else begin
      rise_m = st && !m_prev_step;
      m_prev_step = st;
      go = (md == 2'd1) || (md == 2'd2 && (m_req != 0 || rise_m));
      start = 1'b0;
      if (m_phase == 0) begin
        start = go;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_phase == 1) begin
            m_phase = 2;
            m_left = 2 ** (SHIFT + m_div);
          end else if (go) begin
            start = 1'b1;
          end else begin
            m_phase = 0;
          end
        end
      end
      if (start) begin
        m_div = int'(dv);
        m_phase = 1;
        m_left = 2 ** (SHIFT + m_div);
        m_periods = m_periods + 1;
      end
      if (md != 2'd2) m_req = 0;
      else if (start) m_req = 0;
      else if (rise_m) m_req = 1;
      m_tick = start;
    end
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_model();
    check("model_clkOut", {31'd0, clkOut}, {31'd0, (m_phase == 1)});
    check("model_tick", {31'd0, tick}, {31'd0, m_tick});
    check("model_busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
    check("model_periods", periods, m_periods);
  endtask

  // driver: apply inputs, one clkIn edge, compare at the following negedge
  task automatic cycle(input logic r, input logic [1:0] md, input logic [1:0] dv,
                       input logic st);
    rst_n = r; mode = md; divide = dv; step = st;
    @(posedge clkIn);
    model_edge(r, md, dv, st);
    @(negedge clkIn);
    check_model();
  endtask

  typedef struct {
    logic       r;
    logic [1:0] md;
    logic [1:0] dv;
    logic       st;
    logic       e_clk;
    logic       e_tick;
    logic       e_busy;
    int         e_per;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(logic r, logic [1:0] md, logic [1:0] dv, logic st,
                              logic c, logic t, logic b, int p);
    vec_t v;
    v.r = r; v.md = md; v.dv = dv; v.st = st;
    v.e_clk = c; v.e_tick = t; v.e_busy = b; v.e_per = p;
    return v;
  endfunction

  int len;
  int guard;

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; mode = 2'd0; divide = '0; step = 1'b0;
    model_edge(1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clkIn);

    // reset, RUN 2/2, STOP drain, STEP with queued request, reserved mode, mid-HIGH reset
    vecs[0]  = mk(0, 2'd0, 2'd0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 2'd1, 2'd0, 0, 1, 1, 1, 1);
    vecs[2]  = mk(1, 2'd1, 2'd0, 0, 1, 0, 1, 1);
    vecs[3]  = mk(1, 2'd1, 2'd0, 0, 0, 0, 1, 1);
    vecs[4]  = mk(1, 2'd1, 2'd0, 0, 0, 0, 1, 1);
    vecs[5]  = mk(1, 2'd1, 2'd0, 0, 1, 1, 1, 2);
    vecs[6]  = mk(1, 2'd1, 2'd0, 0, 1, 0, 1, 2);
    vecs[7]  = mk(1, 2'd1, 2'd0, 0, 0, 0, 1, 2);
    vecs[8]  = mk(1, 2'd1, 2'd0, 0, 0, 0, 1, 2);
    vecs[9]  = mk(1, 2'd1, 2'd0, 0, 1, 1, 1, 3);
    vecs[10] = mk(1, 2'd0, 2'd0, 0, 1, 0, 1, 3);
    vecs[11] = mk(1, 2'd0, 2'd0, 0, 0, 0, 1, 3);
    vecs[12] = mk(1, 2'd0, 2'd0, 0, 0, 0, 1, 3);
    vecs[13] = mk(1, 2'd0, 2'd0, 0, 0, 0, 0, 3);
    vecs[14] = mk(1, 2'd0, 2'd0, 0, 0, 0, 0, 3);
    vecs[15] = mk(1, 2'd2, 2'd0, 1, 1, 1, 1, 4);
    vecs[16] = mk(1, 2'd2, 2'd0, 0, 1, 0, 1, 4);
    vecs[17] = mk(1, 2'd2, 2'd0, 1, 0, 0, 1, 4);
    vecs[18] = mk(1, 2'd2, 2'd0, 0, 0, 0, 1, 4);
    vecs[19] = mk(1, 2'd2, 2'd0, 0, 1, 1, 1, 5);
    vecs[20] = mk(1, 2'd2, 2'd0, 0, 1, 0, 1, 5);
    vecs[21] = mk(1, 2'd2, 2'd0, 0, 0, 0, 1, 5);
    vecs[22] = mk(1, 2'd2, 2'd0, 0, 0, 0, 1, 5);
    vecs[23] = mk(1, 2'd2, 2'd0, 0, 0, 0, 0, 5);
    vecs[24] = mk(1, 2'd3, 2'd0, 1, 0, 0, 0, 5);
    vecs[25] = mk(1, 2'd1, 2'd0, 0, 1, 1, 1, 6);
    vecs[26] = mk(0, 2'd1, 2'd0, 0, 0, 0, 0, 0);
    vecs[27] = mk(1, 2'd1, 2'd0, 0, 1, 1, 1, 1);

    for (int i = 0; i < 28; i++) begin
      cycle(vecs[i].r, vecs[i].md, vecs[i].dv, vecs[i].st);
      check($sformatf("vec%0d_clkOut", i), {31'd0, clkOut}, {31'd0, vecs[i].e_clk});
      check($sformatf("vec%0d_tick", i), {31'd0, tick}, {31'd0, vecs[i].e_tick});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
      check($sformatf("vec%0d_periods", i), periods, vecs[i].e_per);
    end

    // divide change mid-HIGH: current 2/2 period finishes, next is 16/16
    cycle(1'b1, 2'd1, 2'd3, 1'b0);
    len = 0;
    for (guard = 0; guard < 8 && !tick; guard++) begin
      if (!clkOut) len++;
      cycle(1'b1, 2'd1, 2'd3, 1'b0);
    end
    check("div_change_old_low_len", len, 2);
    check("div_change_new_tick", {31'd0, tick}, 32'd1);
    len = 0;
    for (guard = 0; guard < 40 && clkOut; guard++) begin
      len++;
      cycle(1'b1, 2'd1, 2'd3, 1'b0);
    end
    check("div3_high_len", len, 16);
    len = 0;
    for (guard = 0; guard < 40 && !clkOut; guard++) begin
      len++;
      cycle(1'b1, 2'd1, 2'd3, 1'b0);
    end
    check("div3_low_len", len, 16);

    // STOP in 2nd cycle of a divide=1 HIGH: full 4 high, 4 low, then idle
    for (guard = 0; guard < 40 && !tick; guard++) cycle(1'b1, 2'd1, 2'd1, 1'b0);
    for (guard = 0; guard < 40 && !(tick && dut.div_q == 2'd1); guard++)
      cycle(1'b1, 2'd1, 2'd1, 1'b0);
    len = 1;
    cycle(1'b1, 2'd0, 2'd1, 1'b0);
    for (guard = 0; guard < 20 && clkOut; guard++) begin
      len++;
      cycle(1'b1, 2'd0, 2'd1, 1'b0);
    end
    check("stop_high_len", len, 4);
    len = 0;
    for (guard = 0; guard < 20 && busy; guard++) begin
      len++;
      cycle(1'b1, 2'd0, 2'd1, 1'b0);
    end
    check("stop_low_len", len, 4);
    repeat (3) cycle(1'b1, 2'd0, 2'd1, 1'b0);
    check("stop_parked_clk", {31'd0, clkOut}, 32'd0);

    // STEP request queued, then switch to RUN before LOW ends; step in RUN is ignored
    cycle(1'b1, 2'd2, 2'd0, 1'b1);
    cycle(1'b1, 2'd2, 2'd0, 1'b0);
    cycle(1'b1, 2'd2, 2'd0, 1'b1);
    cycle(1'b1, 2'd1, 2'd0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 2'd1, 2'd0, 1'(i % 3 == 0));
    check("run_still_busy", {31'd0, busy}, 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic       r;
      logic [1:0] md;
      r  = ($urandom_range(0, 299) != 0);
      md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 7) md = mode;
      cycle(r, md, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
